// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared types and constants for the two-requester data-memory arbiter:
//   FSM state encoding, default memory depth, requester id type, the
//   latched command record and an address range helper.
package dmem_arb_pkg;

  // Number of valid 32-bit words; legal word addresses are 0..DEPTH-1.
  localparam int unsigned DMEM_DEPTH = 121;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Requester id: 0 = r0, 1 = r1.
  typedef logic req_id_t;
  localparam req_id_t ID_R0 = 1'b0;
  localparam req_id_t ID_R1 = 1'b1;

  // Command captured on the grant edge; owner selects the response port.
  typedef struct packed {
    req_id_t     owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  // Full 32-bit unsigned compare against the memory depth.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2
//   Two-way round-robin grant. A lone requester always wins; on a tie the
//   requester that did not win the previous grant wins.
//   Ports:
//     req0_i, req1_i  request pair
//     last_i          id of the previous grant winner
//     gnt0_o, gnt1_o  one-hot (or zero) grant
//     win_o           id of the current winner (valid when a grant is set)
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic    req0_i,
  input  logic    req1_i,
  input  req_id_t last_i,
  output logic    gnt0_o,
  output logic    gnt1_o,
  output req_id_t win_o
);

  always_comb begin
    gnt0_o = req0_i & (~req1_i | (last_i == ID_R1));
    gnt1_o = req1_i & (~req0_i | (last_i == ID_R0));
    win_o  = gnt1_o ? ID_R1 : ID_R0;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Arbitrates two requesters onto a single-port data memory with a fixed
//   IDLE -> ACCESS -> RESP sequence per transaction (grant in N, memory
//   access in N+1, response in N+2, next grant earliest in N+3).
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     rN_req/we/addr/wdata     requester N command (held until rN_gnt)
//     rN_gnt                   1-cycle accept pulse (combinational in IDLE)
//     rN_rvalid/rdata/err      1-cycle response; rdata/err qualified by rvalid
//     mem_we/addr/wdata        memory command, driven only in ACCESS
//     mem_rdata                combinational read data at mem_addr
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_gnt,
  output logic        r0_rvalid,
  output logic [31:0] r0_rdata,
  output logic        r0_err,

  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_gnt,
  output logic        r1_rvalid,
  output logic [31:0] r1_rdata,
  output logic        r1_err,

  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  req_id_t     last_q;
  cmd_t        cmd_q;
  logic [31:0] resp_q;

  logic        arb_gnt0, arb_gnt1;
  req_id_t     arb_win;
  logic        grant;
  logic        cmd_ok;

  rr_arb2 u_rr_arb2 (
    .req0_i (r0_req),
    .req1_i (r1_req),
    .last_i (last_q),
    .gnt0_o (arb_gnt0),
    .gnt1_o (arb_gnt1),
    .win_o  (arb_win)
  );

  // Grants only exist in IDLE; rst gates them so every output reads 0
  // while reset is held, even with requests pending.
  always_comb begin
    r0_gnt = arb_gnt0 & (state_q == ST_IDLE) & ~rst;
    r1_gnt = arb_gnt1 & (state_q == ST_IDLE) & ~rst;
    grant  = r0_gnt | r1_gnt;
    cmd_ok = addr_in_range(cmd_q.addr, DEPTH);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (grant) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= ID_R1;
      cmd_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        last_q      <= arb_win;
        cmd_q.owner <= arb_win;
        if (arb_win == ID_R1) begin
          cmd_q.we    <= r1_we;
          cmd_q.addr  <= r1_addr;
          cmd_q.wdata <= r1_wdata;
        end else begin
          cmd_q.we    <= r0_we;
          cmd_q.addr  <= r0_addr;
          cmd_q.wdata <= r0_wdata;
        end
      end
      // Writes and out-of-range accesses return zero data.
      if (state_q == ST_ACCESS) begin
        resp_q <= (cmd_q.we || !cmd_ok) ? '0 : mem_rdata;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ST_ACCESS) begin
      mem_we    = cmd_q.we & cmd_ok;
      mem_addr  = cmd_q.addr;
      mem_wdata = cmd_q.wdata;
    end
  end

  always_comb begin
    r0_rvalid = 1'b0;
    r0_rdata  = '0;
    r0_err    = 1'b0;
    r1_rvalid = 1'b0;
    r1_rdata  = '0;
    r1_err    = 1'b0;
    if (state_q == ST_RESP) begin
      if (cmd_q.owner == ID_R1) begin
        r1_rvalid = 1'b1;
        r1_rdata  = resp_q;
        r1_err    = ~cmd_ok;
      end else begin
        r0_rvalid = 1'b1;
        r0_rdata  = resp_q;
        r0_err    = ~cmd_ok;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int unsigned DEPTH = 121;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_we, r0_gnt, r0_rvalid, r0_err;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;
  logic        r1_req, r1_we, r1_gnt, r1_rvalid, r1_err;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [DEPTH];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural data memory: synchronous write, combinational read.
  always @(posedge clk) begin
    if (mem_we && (mem_addr < DEPTH)) mem[mem_addr[6:0]] <= mem_wdata;
  end
  assign mem_rdata = (mem_addr < DEPTH) ? mem[mem_addr[6:0]] : 32'd0;

  typedef struct {
    string       name;
    logic        r0_req, r0_we;
    logic [31:0] r0_addr, r0_wdata;
    logic        r1_req, r1_we;
    logic [31:0] r1_addr, r1_wdata;
    logic [1:0]  gnt, rvalid, err;   // bit1 = r1, bit0 = r0
    logic [31:0] r0_rdata, r1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [134:0] outs();
    return {r1_gnt, r0_gnt, r1_rvalid, r0_rvalid, r1_err, r0_err,
            r0_rdata, r1_rdata, mem_we, mem_addr, mem_wdata};
  endfunction

  task automatic chk(input string nm, input logic [134:0] act, input logic [134:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic q0, w0, input logic [31:0] a0, d0,
                       input logic q1, w1, input logic [31:0] a1, d1);
    r0_req = q0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
    r1_req = q1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
  endtask

  task automatic idle_inputs();
    drive(L, L, 32'd0, 32'd0, L, L, 32'd0, 32'd0);
  endtask

  task automatic add(input string nm,
                     input logic q0, w0, input logic [31:0] a0, d0,
                     input logic q1, w1, input logic [31:0] a1, d1,
                     input logic [1:0] g, rv, er, input logic [31:0] rd0, rd1,
                     input logic mwe, input logic [31:0] ma, md);
    vec_t v;
    v.name = nm;
    v.r0_req = q0; v.r0_we = w0; v.r0_addr = a0; v.r0_wdata = d0;
    v.r1_req = q1; v.r1_we = w1; v.r1_addr = a1; v.r1_wdata = d1;
    v.gnt = g; v.rvalid = rv; v.err = er; v.r0_rdata = rd0; v.r1_rdata = rd1;
    v.mem_we = mwe; v.mem_addr = ma; v.mem_wdata = md;
    tbl.push_back(v);
  endtask

  localparam logic [31:0] Z = 32'd0;

  initial begin
    logic [1:0] g;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'd0;

    // One entry per cycle: inputs for that cycle and the outputs expected in it.
    add("idle_none", L,L,Z,Z,                 L,L,Z,Z,                 2'b00,2'b00,2'b00, Z,Z, L,Z,Z);
    add("w5_gnt",    H,H,32'd5,32'hDEADBEEF,  L,L,Z,Z,                 2'b01,2'b00,2'b00, Z,Z, L,Z,Z);
    add("w5_acc",    L,L,32'd7,32'h11111111,  L,L,Z,Z,                 2'b00,2'b00,2'b00, Z,Z, H,32'd5,32'hDEADBEEF);
    add("w5_resp",   L,L,Z,Z,                 L,L,Z,Z,                 2'b00,2'b01,2'b00, Z,Z, L,Z,Z);
    add("r5_gnt",    L,L,Z,Z,                 H,L,32'd5,32'h12345678,  2'b10,2'b00,2'b00, Z,Z, L,Z,Z);
    add("r5_acc",    L,L,Z,Z,                 H,L,32'd5,32'h12345678,  2'b00,2'b00,2'b00, Z,Z, L,32'd5,32'h12345678);
    add("r5_resp",   L,L,Z,Z,                 L,L,Z,Z,                 2'b00,2'b10,2'b00, Z,32'hDEADBEEF, L,Z,Z);
    add("oow_gnt",   H,H,32'd121,32'hCAFEF00D, L,L,Z,Z,                2'b01,2'b00,2'b00, Z,Z, L,Z,Z);
    add("oow_acc",   L,L,Z,Z,                 L,L,Z,Z,                 2'b00,2'b00,2'b00, Z,Z, L,32'd121,32'hCAFEF00D);
    add("oow_resp",  L,L,Z,Z,                 L,L,Z,Z,                 2'b00,2'b01,2'b01, Z,Z, L,Z,Z);
    add("oor_gnt",   L,L,Z,Z,                 H,L,32'hFFFFFFFF,Z,      2'b10,2'b00,2'b00, Z,Z, L,Z,Z);
    add("oor_acc",   L,L,Z,Z,                 L,L,Z,Z,                 2'b00,2'b00,2'b00, Z,Z, L,32'hFFFFFFFF,Z);
    add("oor_resp",  L,L,Z,Z,                 L,L,Z,Z,                 2'b00,2'b10,2'b10, Z,Z, L,Z,Z);
    add("w120_gnt",  H,H,32'd120,32'h0BADC0DE, L,L,Z,Z,                2'b01,2'b00,2'b00, Z,Z, L,Z,Z);
    add("w120_acc",  L,L,Z,Z,                 L,L,Z,Z,                 2'b00,2'b00,2'b00, Z,Z, H,32'd120,32'h0BADC0DE);
    add("w120_resp", L,L,Z,Z,                 L,L,Z,Z,                 2'b00,2'b01,2'b00, Z,Z, L,Z,Z);
    add("r120_gnt",  L,L,Z,Z,                 H,L,32'd120,Z,           2'b10,2'b00,2'b00, Z,Z, L,Z,Z);
    add("r120_acc",  L,L,Z,Z,                 L,L,Z,Z,                 2'b00,2'b00,2'b00, Z,Z, L,32'd120,Z);
    add("r120_resp", L,L,Z,Z,                 L,L,Z,Z,                 2'b00,2'b10,2'b00, Z,32'h0BADC0DE, L,Z,Z);
    add("tie1_gnt",  H,H,32'd3,32'h33,        H,L,32'd3,Z,             2'b01,2'b00,2'b00, Z,Z, L,Z,Z);
    add("tie1_acc",  H,H,32'd3,32'h33,        H,L,32'd3,Z,             2'b00,2'b00,2'b00, Z,Z, H,32'd3,32'h33);
    add("tie1_resp", H,H,32'd3,32'h33,        H,L,32'd3,Z,             2'b00,2'b01,2'b00, Z,Z, L,Z,Z);
    add("tie2_gnt",  H,H,32'd3,32'h33,        H,L,32'd3,Z,             2'b10,2'b00,2'b00, Z,Z, L,Z,Z);
    add("tie2_acc",  H,H,32'd3,32'h33,        H,L,32'd3,Z,             2'b00,2'b00,2'b00, Z,Z, L,32'd3,Z);
    add("tie2_resp", H,H,32'd3,32'h33,        H,L,32'd3,Z,             2'b00,2'b10,2'b00, Z,32'h33, L,Z,Z);
    add("tie3_gnt",  H,H,32'd3,32'h33,        H,L,32'd3,Z,             2'b01,2'b00,2'b00, Z,Z, L,Z,Z);
    add("tie3_acc",  L,L,Z,Z,                 L,L,Z,Z,                 2'b00,2'b00,2'b00, Z,Z, H,32'd3,32'h33);
    add("tie3_resp", L,L,Z,Z,                 L,L,Z,Z,                 2'b00,2'b01,2'b00, Z,Z, L,Z,Z);
    add("idle_end",  L,L,Z,Z,                 L,L,Z,Z,                 2'b00,2'b00,2'b00, Z,Z, L,Z,Z);

    // Reset with both requests pending: all outputs must read zero.
    rst = 1'b1;
    drive(H, H, 32'd9, 32'h99, H, H, 32'd9, 32'h99);
    #3;
    chk("reset_outs", outs(), '0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    idle_inputs();

    // Table is applied starting at this negedge, one entry per cycle.
    foreach (tbl[i]) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i].r0_req, tbl[i].r0_we, tbl[i].r0_addr, tbl[i].r0_wdata,
            tbl[i].r1_req, tbl[i].r1_we, tbl[i].r1_addr, tbl[i].r1_wdata);
      #1;
      chk(tbl[i].name, outs(),
          {tbl[i].gnt, tbl[i].rvalid, tbl[i].err, tbl[i].r0_rdata, tbl[i].r1_rdata,
           tbl[i].mem_we, tbl[i].mem_addr, tbl[i].mem_wdata});
    end

    // Reset during the ACCESS cycle of a write: mem_we drops at once, no write lands.
    @(negedge clk);
    drive(H, H, 32'd10, 32'hAAAA5555, L, L, Z, Z);
    #1 chk("abw_gnt", {133'd0, r1_gnt, r0_gnt}, {133'd0, 2'b01});
    @(negedge clk);
    idle_inputs();
    #1 chk("abw_acc_we", {134'd0, mem_we}, {134'd0, H});
    #1 rst = 1'b1;
    #1 chk("abw_rst_outs", outs(), '0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("abw_no_rvalid", {133'd0, r1_rvalid, r0_rvalid}, '0);
      @(negedge clk);
    end
    chk("abw_mem10", {103'd0, mem[10]}, '0);

    // Reset during the ACCESS cycle of a read: no response, next tie goes to r0.
    drive(L, L, Z, Z, H, L, 32'd5, Z);
    #1 chk("abr_gnt", {133'd0, r1_gnt, r0_gnt}, {133'd0, 2'b10});
    @(negedge clk);
    idle_inputs();
    #2 rst = 1'b1;
    #1 chk("abr_rst_outs", outs(), '0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("abr_no_rvalid", {133'd0, r1_rvalid, r0_rvalid}, '0);
      @(negedge clk);
    end
    drive(H, L, 32'd5, Z, H, L, 32'd5, Z);
    #1 chk("abr_tie_r0", {133'd0, r1_gnt, r0_gnt}, {133'd0, 2'b01});

    // Both requesters held from reset: grants alternate r0, r1, ... every 3 cycles.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      g = 2'b00;
      if (c % 3 == 0) g = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("alt_c%0d", c), {133'd0, r1_gnt, r0_gnt}, {133'd0, g});
      @(negedge clk);
    end
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: DEPTH, 121, number of valid 32-bit data-memory words; legal addresses are 0..DEPTH-1.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 r0_req  in  1  requester 0 access request; held with fields stable until r0_gnt.
REQ-005 r0_we  in  1  requester 0: 1 = write, 0 = read.
REQ-006 r0_addr  in  32  requester 0 word address.
REQ-007 r0_wdata  in  32  requester 0 write data.
REQ-008 r0_gnt  out  1  requester 0 request accepted (1-cycle pulse).
REQ-009 r0_rvalid  out  1  requester 0 response valid (1-cycle pulse).
REQ-010 r0_rdata  out  32  requester 0 read data; qualified by r0_rvalid.
REQ-011 r0_err  out  1  requester 0 address out of range; qualified by r0_rvalid.
REQ-012 r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata, r1_err  same directions/widths/meaning as r0_* for requester 1.
REQ-013 mem_we  out  1  write enable to data memory.
REQ-014 mem_addr  out  32  address to data memory.
REQ-015 mem_wdata  out  32  write data to data memory.
REQ-016 mem_rdata  in  32  combinational read data from data memory at mem_addr.

Function
REQ-017 FSM states: IDLE, ACCESS, RESP; IDLE->ACCESS when any req=1; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-018 In IDLE, rN_gnt = rN_req AND (N is arbitration winner), combinational, at most one gnt per cycle; gnt=0 in ACCESS and RESP.
REQ-019 Arbitration: single requester wins; both requesting -> requester that did not win last grant; last_winner resets to 1 (r0 wins first tie).
REQ-020 On grant edge, winner's we/addr/wdata and owner id are latched; later changes on rN_* inputs are ignored.
REQ-021 In ACCESS: mem_addr = latched addr, mem_wdata = latched wdata, mem_we = latched we AND (addr < DEPTH); mem_rdata captured into response register at end of ACCESS.
REQ-022 In IDLE and RESP: mem_we = 0, mem_addr = 0, mem_wdata = 0.
REQ-023 In RESP: owner's rvalid = 1, rdata = captured value (0 for writes and out-of-range), err = (addr >= DEPTH) using full 32-bit unsigned compare; non-owner rvalid/err = 0, rdata = 0.
REQ-024 Latency: gnt in cycle N, memory write at edge ending N+1, rvalid in cycle N+2; next grant earliest N+3.
REQ-025 Out-of-range write never asserts mem_we; out-of-range read returns rdata=0, err=1.
REQ-026 Requester may drop req without grant; no side effect; a req deasserted in the grant cycle still counts as granted.

Reset
REQ-027 rst asserted: state=IDLE, last_winner=1, latched cmd=0, all outputs 0 immediately (asynchronous).
REQ-028 rst during ACCESS or RESP aborts: no rvalid issued; mem_we drops to 0 immediately.

Structure
REQ-029 Package dmem_arb_pkg holds state enum, DEPTH default constant, requester-id type.
REQ-030 Sub-module rr_arb2 (2-way round-robin grant from req pair and last_winner) is the single natural sub-module.

Verification
REQ-031 r0 write addr=5 data=0xDEADBEEF alone -> r0_gnt cycle N, mem_we=1 mem_addr=5 cycle N+1, r0_rvalid err=0 cycle N+2.
REQ-032 r1 read addr=5 after REQ-031 -> r1_rvalid cycle N+2 with r1_rdata=0xDEADBEEF, r0 outputs all 0.
REQ-033 r0 and r1 both hold req continuously from reset -> grants alternate r0,r1,r0,r1 every 3 cycles.
REQ-034 r0 write addr=121 (DEPTH=121) -> mem_we never 1, r0_rvalid with r0_err=1, r0_rdata=0.
REQ-035 rst pulsed during ACCESS of a read -> no rvalid, state IDLE, next tie grants r0.
